// File: rtl/wb_serial_fifo.sv
// -----------------------------------------------------------------------------
// wb_serial_fifo
//   Wishbone byte-stream peripheral with transmit and receive FIFOs, level and
//   threshold status, a sticky TX overflow flag and a maskable level interrupt.
//   It sits between the Wishbone bus and a byte-stream serial core.
//
// Ports
//   wb_clk_i, wb_reset_i   clock, synchronous active-high reset
//   wb_adr_i               register word address (only [3:0] decoded)
//   wb_dat_i / wb_dat_o    write data / registered read data
//   wb_we_i, wb_sel_i      write enable, byte selects (sel[0] gates writes)
//   wb_cyc_i, wb_stb_i     bus cycle / strobe
//   wb_ack_o               registered single-cycle acknowledge
//   tx_data, tx_valid      head of TX FIFO, TX FIFO non-empty
//   tx_ready               core takes tx_data this cycle
//   rx_data, rx_valid      byte offered by the core
//   rx_get                 offered byte consumed this cycle (combinational)
//   irq                    registered level interrupt
//
// Register map (word address)
//   0 DATA  read pops RX head, write pushes TX byte
//   1 IER   [4:0] interrupt enables
//   2 ISR   {RXTH, TXOVF, TXE, TXNF, RXNE}; TXOVF is write-1-to-clear
//   3 LEVEL [7:0] RX count, [15:8] TX count
//   4 CTRL  bit0 flush RX, bit1 flush TX (self-clearing), [15:8] RX threshold
// -----------------------------------------------------------------------------
module wb_serial_fifo #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_we_i,
    input  logic [DW/8-1:0] wb_sel_i,
    output logic            wb_ack_o,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_get,
    output logic            irq
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;
    localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);

    localparam logic [3:0] A_DATA  = 4'd0;
    localparam logic [3:0] A_IER   = 4'd1;
    localparam logic [3:0] A_ISR   = 4'd2;
    localparam logic [3:0] A_LEVEL = 4'd3;
    localparam logic [3:0] A_CTRL  = 4'd4;

    // Storage and state
    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [TAW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RAW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [4:0]     ier_q, ier_d;
    logic [7:0]     thr_q, thr_d;
    logic           txovf_q, txovf_d;
    logic           ack_q, ack_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic           irq_q, irq_d;

    // Decoded access
    logic       stb, wr_en, rd_en;
    logic [3:0] adr;
    logic       tx_push, tx_pop, tx_ovf_set, flush_tx;
    logic       rx_pop, flush_rx;
    logic [4:0] isr;

    // Only adr[3:0], dat[15:0] and sel[1:0] are decoded; fold the rest away.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

    assign adr   = wb_adr_i[3:0];
    // The ack of the previous cycle masks the strobe, so one access acks once.
    assign stb   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en = stb & wb_we_i & wb_sel_i[0];
    assign rd_en = stb & ~wb_we_i;

    assign tx_valid = (tx_cnt_q != '0);
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign tx_pop   = tx_valid & tx_ready;
    // Full is judged on the count before this cycle's pop.
    assign tx_push    = wr_en & (adr == A_DATA) & (tx_cnt_q != TX_FULL);
    assign tx_ovf_set = wr_en & (adr == A_DATA) & (tx_cnt_q == TX_FULL);
    assign flush_tx   = wr_en & (adr == A_CTRL) & wb_dat_i[1];

    assign rx_get   = rx_valid & (rx_cnt_q != RX_FULL);
    assign rx_pop   = rd_en & (adr == A_DATA) & (rx_cnt_q != '0);
    assign flush_rx = wr_en & (adr == A_CTRL) & wb_dat_i[0];

    assign isr = {(8'(rx_cnt_q) >= thr_q), txovf_q, (tx_cnt_q == '0),
                  (tx_cnt_q != TX_FULL), (rx_cnt_q != '0)};

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = irq_q;

    // FIFO pointer and count update; a flush overrides any push or pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (flush_tx) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
                default: tx_cnt_d = tx_cnt_q;
            endcase
        end

        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (flush_rx) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_get) rx_wptr_d = rx_wptr_q + 1'b1;
            if (rx_pop) rx_rptr_d = rx_rptr_q + 1'b1;
            case ({rx_get, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    // Control registers, read mux, ack and interrupt.
    always_comb begin
        ier_d   = ier_q;
        thr_d   = thr_q;
        txovf_d = txovf_q;
        if (wr_en && adr == A_IER) ier_d = wb_dat_i[4:0];
        if (wr_en && adr == A_CTRL && wb_sel_i[1])
            thr_d = (wb_dat_i[15:8] == 8'd0) ? 8'd1 : wb_dat_i[15:8];
        if (wr_en && adr == A_ISR && wb_dat_i[3]) txovf_d = 1'b0;
        // A new overflow in the same cycle as the clear must not be lost.
        if (tx_ovf_set) txovf_d = 1'b1;

        dat_d = '0;
        if (rd_en) begin
            case (adr)
                A_DATA:  if (rx_cnt_q != '0) dat_d[7:0] = rx_mem_q[rx_rptr_q];
                A_IER:   dat_d[4:0]  = ier_q;
                A_ISR:   dat_d[4:0]  = isr;
                A_LEVEL: dat_d[15:0] = {8'(tx_cnt_q), 8'(rx_cnt_q)};
                A_CTRL:  dat_d[15:8] = thr_q;
                default: dat_d = '0;
            endcase
        end

        ack_d = stb;
        irq_d = |(isr & ier_q);
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (wb_reset_i) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            ier_q     <= '0;
            thr_q     <= 8'd1;
            txovf_q   <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            ier_q     <= ier_d;
            thr_q     <= thr_d;
            txovf_q   <= txovf_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    // NOTE: FIFO storage has no reset; pointers and counts define validity, so contents never matter after reset.
    always_ff @(posedge wb_clk_i) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= wb_dat_i[7:0];
        if (rx_get)  rx_mem_q[rx_wptr_q] <= rx_data;
    end

endmodule
